// File: rtl/fifo_pkg.sv
// Shared definitions for the 10-bit synchronous FIFO and its read-side controller.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READING = 2'd1,
    STALL   = 2'd2,
    ERR     = 2'd3
  } reader_state_t;

  // A new pop may issue only if the word it returns is guaranteed a buffer slot.
  function automatic logic has_credit(input logic [1:0] occupancy, input logic in_flight);
    return ({1'b0, occupancy} + {2'b00, in_flight}) < 3'd2;
  endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry circular output buffer between the FIFO read port and the downstream handshake.
module fifo_reader_skid
  import fifo_pkg::*;
#(
  parameter int tamano_datos = FIFO_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [tamano_datos-1:0] push_data,
  input  logic                    pop,
  output logic [tamano_datos-1:0] data,
  output logic                    valid,
  output logic [1:0]              occupancy
);

  logic [tamano_datos-1:0] entry [2];
  logic                    head;
  logic                    tail;
  logic                    do_pop;

  assign do_pop = pop & valid;

  // NOTE: the storage is reset as well because data_out must read zero straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry[0]  <= '0;
      entry[1]  <= '0;
      head      <= 1'b0;
      tail      <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      // NOTE: non-blocking keeps every register reading pre-edge values, so push and pop can share a cycle.
      if (push) begin
        entry[tail] <= push_data;
        tail        <= ~tail;
      end
      if (do_pop) head <= ~head;
      case ({push, do_pop})
        2'b10:   occupancy <= occupancy + 2'd1;
        2'b01:   occupancy <= occupancy - 2'd1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  assign data  = entry[head];
  assign valid = (occupancy != 2'd0);

endmodule

// File: rtl/fifo_reader.sv
// Read-side controller: pops the FIFO under a 2-slot credit, buffers returned words, delivers on valid/ready.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int tamano_datos    = FIFO_DATA_WIDTH,
  parameter int tamano_contador = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       fifo_empty,
  input  logic                       fifo_error,
  input  logic [tamano_datos-1:0]    fifo_data_out,
  output logic                       read_enable,
  output logic                       data_valid,
  output logic [tamano_datos-1:0]    data_out,
  input  logic                       data_ready,
  output logic [tamano_contador-1:0] words_read,
  output logic                       error,
  output logic                       busy
);

  reader_state_t state;
  reader_state_t next_state;
  logic          in_flight;
  logic          empty_at_issue;
  logic [1:0]    occupancy;
  logic          pop;
  logic          fault;
  logic          credit;

  assign credit = has_credit(occupancy, in_flight);
  assign pop    = data_valid & data_ready;

  // Gated by reset so no pop request can escape while the controller is held in reset.
  assign read_enable = enable & ~fifo_empty & credit & (state != ERR) & ~reset;

  // A word in flight from a read issued against an empty FIFO means the FIFO handed back garbage.
  assign fault = fifo_error | (in_flight & empty_at_issue);

  fifo_reader_skid #(
    .tamano_datos(tamano_datos)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .push     (in_flight),
    .push_data(fifo_data_out),
    .pop      (pop),
    .data     (data_out),
    .valid    (data_valid),
    .occupancy(occupancy)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      in_flight      <= 1'b0;
      empty_at_issue <= 1'b0;
      words_read     <= '0;
    end else begin
      state          <= next_state;
      in_flight      <= read_enable;
      empty_at_issue <= fifo_empty;
      if (pop) words_read <= words_read + {{(tamano_contador-1){1'b0}}, 1'b1};
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch is inferred.
    next_state = state;
    case (state)
      IDLE: begin
        if (read_enable) next_state = READING;
      end
      READING: begin
        if (!credit && !data_ready)
          next_state = STALL;
        else if (occupancy == 2'd0 && !in_flight && !read_enable)
          next_state = IDLE;
      end
      STALL: begin
        if (pop) next_state = READING;
      end
      ERR: begin
        next_state = ERR;
      end
      default: next_state = IDLE;
    endcase
    if (fault) next_state = ERR;
  end

  assign error = (state == ERR);
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: a queue-based FIFO and reader model predict every output cycle by cycle.
module tb_fifo_reader;
  import fifo_pkg::*;

  localparam int W = FIFO_DATA_WIDTH;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         fifo_empty;
  logic         fifo_error;
  logic [W-1:0] fifo_data_out;
  logic         data_ready;
  logic         read_enable, data_valid, error, busy;
  logic [W-1:0] data_out;
  logic [15:0]  words_read;
  logic         re4, dv4, err4, busy4;
  logic [W-1:0] do4;
  logic [3:0]   wr4;

  always #5 clk = ~clk;

  fifo_reader dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty), .fifo_error(fifo_error),
    .fifo_data_out(fifo_data_out), .read_enable(read_enable), .data_valid(data_valid),
    .data_out(data_out), .data_ready(data_ready), .words_read(words_read), .error(error), .busy(busy)
  );

  fifo_reader #(.tamano_contador(4)) dut_w4 (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty), .fifo_error(fifo_error),
    .fifo_data_out(fifo_data_out), .read_enable(re4), .data_valid(dv4),
    .data_out(do4), .data_ready(data_ready), .words_read(wr4), .error(err4), .busy(busy4)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: FIFO contents, buffered words, one outstanding read, sticky error, delivered count.
  logic [W-1:0] fifo_q [$];
  logic [W-1:0] out_q [$];
  logic [W-1:0] sent [$];
  logic [W-1:0] dut_delivered [$];
  bit           m_inflight = 0;
  bit           m_err = 0;
  bit           force_empty = 0;
  int unsigned  m_count = 0;
  int           reads_obs = 0;
  int           cycle = 0;
  int           first_re = -1;
  int           first_dv = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic update_empty();
    fifo_empty = (fifo_q.size() == 0) || force_empty;
  endtask

  task automatic preload(input int n);
    sent.delete();
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(W'($urandom));
      sent.push_back(fifo_q[fifo_q.size()-1]);
    end
    update_empty();
  endtask

  // One clock cycle: called just after a falling edge with inputs already applied.
  task automatic tick();
    bit           exp_re;
    bit           pop;
    logic [W-1:0] cap;
    #1;
    exp_re = enable && !fifo_empty && (out_q.size() + int'(m_inflight) < 2) && !m_err;
    check("read_enable", read_enable, exp_re);
    check("read_enable_w4", re4, exp_re);
    check("data_valid", data_valid, out_q.size() != 0);
    check("data_valid_w4", dv4, out_q.size() != 0);
    if (out_q.size() != 0) begin
      check("data_out", data_out, out_q[0]);
      check("data_out_w4", do4, out_q[0]);
    end
    check("words_read", words_read, m_count[15:0]);
    check("words_read_w4", wr4, m_count[3:0]);
    check("error", error, m_err);
    check("error_w4", err4, m_err);
    if (read_enable) reads_obs++;
    if (read_enable && first_re < 0) first_re = cycle;
    if (data_valid && first_dv < 0) first_dv = cycle;
    if (data_valid && data_ready) dut_delivered.push_back(data_out);
    pop = (out_q.size() != 0) && data_ready;
    cap = fifo_data_out;
    @(posedge clk);
    if (pop) begin
      out_q.delete(0);
      m_count++;
    end
    if (m_inflight) out_q.push_back(cap);
    if (fifo_error) m_err = 1;
    m_inflight = exp_re;
    #1;
    if (exp_re) fifo_data_out = fifo_q.pop_front();
    else        fifo_data_out = W'($urandom);
    update_empty();
    cycle++;
    @(negedge clk);
  endtask

  task automatic drain(input bit random_ready, input int budget);
    int n = 0;
    while ((fifo_q.size() != 0 || out_q.size() != 0 || m_inflight) && n < budget) begin
      if (random_ready) data_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    check("drain_budget", n < budget, 1);
    data_ready = 1'b1;
  endtask

  // Reset asserted between clock edges; outputs must clear before the next rising edge.
  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_read_enable", read_enable, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_words_read", words_read, 0);
    check("rst_words_read_w4", wr4, 0);
    check("rst_error", error, 0);
    check("rst_busy", busy, 0);
    check("rst_busy_w4", busy4, 0);
    out_q.delete();
    fifo_q.delete();
    dut_delivered.delete();
    m_inflight = 0;
    m_err = 0;
    m_count = 0;
    update_empty();
    @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    fifo_error = 1'b0;
    data_ready = 1'b0;
    fifo_data_out = '0;
    update_empty();
    @(negedge clk);
    async_reset();

    // Basic drain of three known words.
    fifo_q = '{10'b0010010001, 10'b0001001010, 10'b0010010011};
    update_empty();
    data_ready = 1'b1;
    enable = 1'b1;
    cycle = 0;
    first_re = -1;
    first_dv = -1;
    drain(0, 50);
    check("first_valid_latency", first_dv - first_re, 2);
    check("basic_count", dut_delivered.size(), 3);
    if (dut_delivered.size() == 3) begin
      check("basic_w0", dut_delivered[0], 10'b0010010001);
      check("basic_w1", dut_delivered[1], 10'b0001001010);
      check("basic_w2", dut_delivered[2], 10'b0010010011);
    end
    tick();
    tick();
    check("basic_words_read", words_read, 3);
    check("basic_idle_busy", busy, 0);
    check("basic_idle_state", dut.state, IDLE);

    // Backpressure: only two reads may issue against a stalled consumer.
    async_reset();
    enable = 1'b1;
    data_ready = 1'b0;
    preload(8);
    reads_obs = 0;
    repeat (6) tick();
    check("bp_reads", reads_obs, 2);
    check("bp_occupancy", dut.occupancy, 2);
    check("bp_state", dut.state, STALL);
    check("bp_busy", busy, 1);
    check("bp_read_enable", read_enable, 0);
    data_ready = 1'b1;
    drain(0, 100);
    check("bp_delivered", dut_delivered.size(), 8);
    for (int i = 0; i < 8 && i < dut_delivered.size(); i++)
      check("bp_order", dut_delivered[i], sent[i]);
    check("bp_words_read", words_read, 8);

    // Streaming with the consumer always ready, then with random backpressure.
    dut_delivered.delete();
    preload(30);
    data_ready = 1'b1;
    drain(0, 200);
    check("stream_delivered", dut_delivered.size(), 30);
    for (int i = 0; i < 30 && i < dut_delivered.size(); i++)
      check("stream_order", dut_delivered[i], sent[i]);
    dut_delivered.delete();
    preload(30);
    drain(1, 400);
    check("random_delivered", dut_delivered.size(), 30);

    // An empty flag arriving with credit available must block the read.
    fifo_q.push_back(W'($urandom));
    force_empty = 1;
    update_empty();
    reads_obs = 0;
    repeat (3) tick();
    check("forced_empty_reads", reads_obs, 0);
    force_empty = 0;
    update_empty();
    drain(0, 50);

    // enable drops one cycle after a read issues.
    repeat (2) tick();
    dut_delivered.delete();
    fifo_q = '{10'b0101100100, 10'h2aa, 10'h155};
    update_empty();
    reads_obs = 0;
    tick();
    enable = 1'b0;
    repeat (6) tick();
    check("toggle_reads", reads_obs, 1);
    check("toggle_delivered", dut_delivered.size(), 1);
    if (dut_delivered.size() == 1) check("toggle_word", dut_delivered[0], 10'b0101100100);
    enable = 1'b1;
    drain(0, 50);
    check("toggle_total", dut_delivered.size(), 3);

    // Error pulse with one word buffered.
    async_reset();
    enable = 1'b1;
    data_ready = 1'b0;
    preload(1);
    repeat (4) tick();
    check("err_pre_occupancy", dut.occupancy, 1);
    fifo_error = 1'b1;
    tick();
    fifo_error = 1'b0;
    fifo_q.push_back(W'($urandom));
    fifo_q.push_back(W'($urandom));
    update_empty();
    reads_obs = 0;
    repeat (3) tick();
    check("err_sticky", error, 1);
    check("err_no_reads", reads_obs, 0);
    data_ready = 1'b1;
    repeat (3) tick();
    check("err_drained", dut_delivered.size(), 1);
    if (dut_delivered.size() == 1) check("err_word", dut_delivered[0], sent[0]);
    check("err_still_set", error, 1);
    check("err_state", dut.state, ERR);

    // Asynchronous reset while stalled.
    async_reset();
    enable = 1'b1;
    data_ready = 1'b0;
    preload(5);
    repeat (5) tick();
    check("stall_before_reset", dut.state, STALL);
    async_reset();
    repeat (2) tick();

    // Counter wrap on the 4-bit instance.
    enable = 1'b1;
    preload(17);
    drain(1, 300);
    check("wrap_w4", wr4, 1);
    check("wrap_w16", words_read, 17);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
